// File: rtl/dsp_accum_pipe.sv
// Two-stage pre-add / accumulate block between the multiplier array and the output bank.
// Same two-cycle latency for every mode; the accumulator persists across other modes and bubbles.
module dsp_accum_pipe #(
    parameter int IN_W  = 36,
    parameter int ACC_W = 44,
    parameter bit SAT   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        mode,
    input  logic              add_previous,
    input  logic [2*IN_W-1:0] A,
    input  logic [2*IN_W-1:0] B,
    input  logic [ACC_W-1:0]  C,
    output logic              out_valid,
    output logic [4*IN_W-1:0] S,
    output logic              overflow
);

    localparam int S_W = 4 * IN_W;

    if (ACC_W < IN_W + 1 || ACC_W > 4 * IN_W) begin : g_bad_width
        $error("dsp_accum_pipe: ACC_W must satisfy IN_W+1 <= ACC_W <= 4*IN_W");
    end

    typedef enum logic [1:0] {
        M_PASS  = 2'b00,
        M_ADD   = 2'b01,
        M_ACC   = 2'b10,
        M_ACC_C = 2'b11
    } mode_e;

    logic             v1;
    mode_e            mode1;
    logic             ap1;
    logic [ACC_W-1:0] c1;
    logic [S_W-1:0]   ab1;
    logic [ACC_W-1:0] sum1;

    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1    <= 1'b0;
            mode1 <= M_PASS;
            ap1   <= 1'b0;
            c1    <= '0;
            ab1   <= '0;
            sum1  <= '0;
        end else begin
            v1    <= in_valid;
            mode1 <= mode_e'(mode);
            ap1   <= add_previous;
            c1    <= C;
            ab1   <= {A, B};
            sum1  <= ACC_W'(A[IN_W-1:0]) + ACC_W'(B[IN_W-1:0]);
        end
    end

    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   wide;
    logic             ovf_ev;
    logic [ACC_W-1:0] r;
    logic [ACC_W-1:0] acc_n;
    logic             ovf_n;
    logic [S_W-1:0]   s_n;

    always_comb begin
        base   = '0;
        wide   = '0;
        ovf_ev = 1'b0;
        r      = '0;
        acc_n  = acc;
        ovf_n  = overflow;
        s_n    = S;
        unique case (mode1)
            M_PASS: s_n = ab1;
            M_ADD: begin
                r   = ap1 ? sum1 + c1 : sum1;
                s_n = S_W'(r) << (S_W - ACC_W);
            end
            M_ACC, M_ACC_C: begin
                // add_previous=0 restarts the chain: load sum (ACC) or C+sum (ACC_C)
                if (ap1)
                    base = acc;
                else if (mode1 == M_ACC_C)
                    base = c1;
                wide   = {1'b0, base} + {1'b0, sum1};
                ovf_ev = wide[ACC_W];
                r      = (SAT && ovf_ev) ? '1 : wide[ACC_W-1:0];
                acc_n  = r;
                ovf_n  = (ap1 & overflow) | ovf_ev;
                s_n    = S_W'(r) << (S_W - ACC_W);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            S         <= '0;
            acc       <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                S        <= s_n;
                acc      <= acc_n;
                overflow <= ovf_n;
            end
        end
    end

endmodule

// File: tb/tb_dsp_accum_pipe.sv
// Scoreboard bench for dsp_accum_pipe: directed vectors, queued expectations,
// monitor pops on every out_valid.
module tb_dsp_accum_pipe;

    localparam int IN_W  = 36;
    localparam int ACC_W = 44;
    localparam int S_W   = 4 * IN_W;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [1:0]        mode;
    logic              add_previous;
    logic [2*IN_W-1:0] A;
    logic [2*IN_W-1:0] B;
    logic [ACC_W-1:0]  C;
    logic              out_valid;
    logic [S_W-1:0]    S;
    logic              overflow;

    dsp_accum_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .SAT(1'b1)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .mode(mode),
        .add_previous(add_previous),
        .A(A),
        .B(B),
        .C(C),
        .out_valid(out_valid),
        .S(S),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [S_W-1:0] s;
        logic           ov;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    localparam logic [ACC_W-1:0] ONES = {ACC_W{1'b1}};

    function automatic logic [S_W-1:0] pk(input logic [ACC_W-1:0] r);
        return {r, {(S_W - ACC_W){1'b0}}};
    endfunction

    // Monitor: every presented output must match the oldest expectation
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output S=%h", S);
            end else begin
                e = q.pop_front();
                if (S !== e.s || overflow !== e.ov) begin
                    errors++;
                    $display("FAIL scoreboard S=%h ov=%b expected S=%h ov=%b",
                             S, overflow, e.s, e.ov);
                end
            end
        end
    end

    task automatic send(input logic v, input logic [1:0] m, input logic ap,
                        input logic [2*IN_W-1:0] a, input logic [2*IN_W-1:0] b,
                        input logic [ACC_W-1:0] c, input logic push,
                        input logic [S_W-1:0] es, input logic eov);
        exp_t e;
        in_valid     = v;
        mode         = m;
        add_previous = ap;
        A            = a;
        B            = b;
        C            = c;
        if (push) begin
            e.s  = es;
            e.ov = eov;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [S_W-1:0] act,
                       input logic [S_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    localparam logic [2*IN_W-1:0] PA = 72'hABAB_CDCD_EFEF_0123_45;
    localparam logic [2*IN_W-1:0] PB = 72'hCDCD_1234_5678_9ABC_DE;
    localparam logic [2*IN_W-1:0] HI = {36'hFFF_FFFF_FF, 36'h0};

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        mode = 2'b00;
        add_previous = 1'b0;
        A = '0;
        B = '0;
        C = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", S_W'(out_valid), '0);
        chk("reset_S", S, '0);
        chk("reset_overflow", S_W'(overflow), '0);
        reset = 1'b0;

        // ADD: plain, with C, wrap (upper halves of A/B are ignored)
        send(1, 2'b01, 0, 72'd5, 72'd7, 44'd0, 1, pk(44'd12), 0);
        send(1, 2'b01, 1, HI | 72'd1, 72'd2, 44'd100, 1, pk(44'd103), 0);
        send(1, 2'b01, 1, 72'd1, 72'd1, ONES, 1, pk(44'd1), 0);

        // ACC chain 1,3,6,10
        send(1, 2'b10, 0, 72'd1, 72'd0, 44'd0, 1, pk(44'd1), 0);
        send(1, 2'b10, 1, 72'd1, 72'd1, 44'd0, 1, pk(44'd3), 0);
        send(1, 2'b10, 1, 72'd2, 72'd1, 44'd0, 1, pk(44'd6), 0);
        send(1, 2'b10, 1, 72'd3, 72'd1, 44'd0, 1, pk(44'd10), 0);

        // ACC chain with a bubble between samples 2 and 3
        send(1, 2'b10, 0, 72'd1, 72'd0, 44'd0, 1, pk(44'd1), 0);
        send(1, 2'b10, 1, 72'd2, 72'd0, 44'd0, 1, pk(44'd3), 0);
        send(0, 2'b10, 1, 72'd9, 72'd9, 44'd0, 0, '0, 0);
        send(1, 2'b10, 1, 72'd3, 72'd0, 44'd0, 1, pk(44'd6), 0);
        chk("bubble_out_valid", S_W'(out_valid), '0);
        chk("bubble_S_hold", S, pk(44'd3));
        send(1, 2'b10, 1, 72'd4, 72'd0, 44'd0, 1, pk(44'd10), 0);

        // ACC_C preload then saturating overflow; ADD carry leaves flag alone
        send(1, 2'b11, 0, 72'd5, 72'd0, ONES - 44'd9, 1, pk(ONES - 44'd4), 0);
        send(1, 2'b11, 1, 72'd20, 72'd0, 44'd0, 1, pk(ONES), 1);
        send(1, 2'b01, 1, 72'd2, 72'd0, ONES, 1, pk(44'd1), 1);
        send(1, 2'b10, 0, 72'd3, 72'd0, 44'd0, 1, pk(44'd3), 0);

        // PASS does not disturb acc (3)
        send(1, 2'b00, 1, PA, PB, 44'd0, 1, {PA, PB}, 0);
        send(1, 2'b10, 1, 72'd4, 72'd0, 44'd0, 1, pk(44'd7), 0);

        // Preload that itself overflows keeps the flag, next preload clears it
        send(1, 2'b11, 0, 72'd2, 72'd0, ONES, 1, pk(ONES), 1);
        send(1, 2'b11, 0, 72'd1, 72'd0, 44'd5, 1, pk(44'd6), 0);

        // Reset right behind a valid sample: that sample is discarded
        send(1, 2'b10, 1, 72'd1, 72'd0, 44'd0, 0, '0, 0);
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst2_out_valid", S_W'(out_valid), '0);
        chk("rst2_S", S, '0);
        chk("rst2_overflow", S_W'(overflow), '0);
        reset = 1'b0;
        send(1, 2'b10, 1, 72'd4, 72'd0, 44'd0, 1, pk(44'd4), 0);
        send(0, 2'b00, 0, 72'd0, 72'd0, 44'd0, 0, '0, 0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_accum_pipe.md
Name: dsp_accum_pipe

Overview:
- Parametrised, fully pipelined pre-add/accumulate block for the DSP block model.
- Successor to the fixed 36/44-bit adder-accumulator. Adds:
  - configurable widths;
  - a 2-bit mode select;
  - uniform latency for all modes;
  - valid qualification with bubble support;
  - a persistent accumulator with load/accumulate control;
  - optional saturation with a sticky overflow flag.
- Sits between the multiplier array outputs and the block output register bank.

Parameters:
- IN_W, 36, width of each operand lane (low half of A/B used for the pre-add).
- ACC_W, 44, accumulator/result width. Elaboration error unless IN_W+1 <= ACC_W <= 4*IN_W.
- SAT, 1, 1 = saturate accumulator at 2^ACC_W-1; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input qualifier.
- mode  in  2  00 PASS, 01 ADD, 10 ACC, 11 ACC_C.
- add_previous  in  1  per-sample accumulate/add-C control.
- A  in  2*IN_W  operand A (unsigned).
- B  in  2*IN_W  operand B (unsigned).
- C  in  ACC_W  addend / accumulator preload (unsigned).
- out_valid  out  1  S and overflow valid.
- S  out  4*IN_W  result.
- overflow  out  1  sticky accumulator overflow flag.

Behaviour:
- Reset is synchronous and active-high: reset=1 at a rising clk edge clears all state.
  - Cleared: stage-1 regs, acc, S, out_valid, overflow (all 0).
  - Reset dominates in_valid; in-flight samples are discarded.
  - out_valid is 0 after the edge where reset is sampled.
- Pipeline, latency 2 in every mode:
  - Edge 1 captures in_valid, mode, add_previous, C, {A,B}, and sum = A[IN_W-1:0]+B[IN_W-1:0] (IN_W+1 bits, zero-extended to ACC_W).
  - Edge 2 computes the result, updates acc/overflow, and registers S and out_valid.
  - A sample presented at edge n appears at edge n+1 (out_valid=1 from then).
  - Full throughput: one sample per cycle.
- Bubbles (stage-1 valid=0):
  - out_valid <= 0.
  - S, acc and overflow hold.
- Result by mode (stage-2, valid=1), r is ACC_W bits:
  - PASS: S <= {A,B}. acc and overflow untouched.
  - ADD: r = add_previous ? sum+C : sum. Always wraps; never saturates. acc and overflow untouched.
  - ACC: add_previous=1 → r = acc+sum; add_previous=0 → r = sum (load). acc <= r.
  - ACC_C: add_previous=1 → r = acc+sum; add_previous=0 → r = C+sum (preload). acc <= r.
- Output packing for ADD/ACC/ACC_C:
  - S = {r, (4*IN_W-ACC_W) zeros}, i.e. the result is MSB-aligned.
- Accumulator feedback:
  - acc used at edge n+1 includes the sample accepted at edge n.
  - Back-to-back accumulates therefore chain with no gap.
- Saturation and overflow:
  - An ACC/ACC_C sum carry-out beyond ACC_W bits is an overflow event.
  - SAT=1: r clamps to all-ones. SAT=0: r wraps.
  - Overflow event sets the overflow flag (sticky).
  - Any load or preload (add_previous=0 in ACC/ACC_C) clears overflow, unless that same operation overflows.
  - ADD-mode carry never affects the overflow flag.
- Mode may change every sample. acc persists across PASS/ADD samples and bubbles.

Test Plan:
- Reset, then mode=01, add_previous=0, A[35:0]=5, B[35:0]=7 at edge 1 → edge 2: out_valid=1, S[143:100]=12, S[99:0]=0.
- mode=10, four consecutive valid samples with sum=1,2,3,4 (first add_previous=0, rest 1) → S[143:100]=1,3,6,10 on four consecutive cycles; out_valid high throughout.
- ACC with a bubble (in_valid=0) inserted between samples 2 and 3 → out_valid drops for one cycle, S holds 3, final value 10.
- mode=11, add_previous=0, C=2^44-10, sum=5, then add_previous=1, sum=20 (SAT=1) → S[143:100]=2^44-5, then 2^44-1 with overflow=1. A following load with sum=3 → 3, overflow=0.
- mode=00, A=72'hAB..., B=72'hCD... → S={A,B} after 2 edges; a subsequent ACC continuation still uses the pre-PASS acc value.
- Assert reset in the cycle after a valid ACC sample → out_valid=0, S=0, overflow=0 next cycle. Next accumulate after reset starts from acc=0.
